// File: rtl/dashboard_view_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dashboard_view_ctrl
// Brief    : Debounced view-mode selector, statistics sequencer and freezable
//            display mux between the board buttons and the 7-segment driver.
// Revision : 1.0 - initial release
// ============================================================================
module dashboard_view_ctrl #(
    parameter  int DATA_W       = 32,
    parameter  int NUM_STAT     = 4,
    parameter  int DEBOUNCE     = 20000,
    parameter  int SCROLL_TICKS = 50000000,
    localparam int SEL_W        = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_u,
    input  logic                         btn_d,
    input  logic                         btn_l,
    input  logic                         btn_r,
    input  logic                         freeze_sw,
    input  logic                         scroll_sw,
    input  logic [DATA_W-1:0]            ordinary_in,
    input  logic [DATA_W-1:0]            memory_in,
    input  logic [DATA_W-1:0]            pc_in,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_in,
    output logic [1:0]                   mode,
    output logic [SEL_W-1:0]             stat_sel,
    output logic                         frozen,
    output logic [DATA_W-1:0]            display_out
);

    localparam int c_db_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int c_sc_w = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [c_db_w-1:0] c_db_last  = c_db_w'(DEBOUNCE - 1);
    localparam logic [c_sc_w-1:0] c_sc_last  = c_sc_w'(SCROLL_TICKS - 1);
    localparam logic [SEL_W-1:0]  c_sel_last = SEL_W'(NUM_STAT - 1);

    typedef enum logic [1:0] {
        MODE_ORD  = 2'd0,
        MODE_MEM  = 2'd1,
        MODE_PC   = 2'd2,
        MODE_STAT = 2'd3
    } mode_t;

    // Raw input bit order: 0=U 1=D 2=L 3=R 4=freeze 5=scroll
    logic [5:0]        r_meta;
    logic [5:0]        r_sync;
    logic [3:0]        r_level;
    logic [3:0]        r_level_q;
    logic [c_db_w-1:0] r_db_cnt [4];
    logic [3:0]        w_press;

    mode_t             r_mode;
    logic [SEL_W-1:0]  r_stat_sel;
    logic [c_sc_w-1:0] r_scroll_cnt;
    logic [SEL_W-1:0]  w_sel_next;
    logic              w_scroll_active;

    logic [DATA_W-1:0] w_stat_word;
    logic [DATA_W-1:0] w_live;
    logic [DATA_W-1:0] r_display;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {scroll_sw, freeze_sw, btn_r, btn_l, btn_d, btn_u};
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level   <= '0;
            r_level_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_level_q <= r_level;
            for (int i = 0; i < 4; i++) begin
                if (r_sync[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_db_last) begin
                    r_db_cnt[i] <= '0;
                    r_level[i]  <= r_sync[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press         = r_level & ~r_level_q;
    assign w_sel_next      = (r_stat_sel == c_sel_last) ? '0 : r_stat_sel + 1'b1;
    assign w_scroll_active = r_sync[5] && (r_mode == MODE_STAT);

    // Every accepted press restarts the scroll period; leaving STAT thereby
    // clears the counter on the same edge the mode changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= MODE_ORD;
            r_stat_sel   <= '0;
            r_scroll_cnt <= '0;
        end else if (w_press[0]) begin
            r_mode       <= MODE_ORD;
            r_scroll_cnt <= '0;
        end else if (w_press[1]) begin
            r_mode       <= MODE_MEM;
            r_scroll_cnt <= '0;
        end else if (w_press[2]) begin
            r_mode       <= MODE_PC;
            r_scroll_cnt <= '0;
        end else if (w_press[3]) begin
            if (r_mode == MODE_STAT) begin
                r_stat_sel <= w_sel_next;
            end else begin
                r_mode <= MODE_STAT;
            end
            r_scroll_cnt <= '0;
        end else if (w_scroll_active) begin
            if (r_scroll_cnt == c_sc_last) begin
                r_scroll_cnt <= '0;
                r_stat_sel   <= w_sel_next;
            end else begin
                r_scroll_cnt <= r_scroll_cnt + 1'b1;
            end
        end else begin
            r_scroll_cnt <= '0;
        end
    end

    always_comb begin
        w_stat_word = '0;
        for (int k = 0; k < NUM_STAT; k++) begin
            if (r_stat_sel == SEL_W'(k)) begin
                w_stat_word = stat_in[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_live = ordinary_in;
        case (r_mode)
            MODE_ORD:  w_live = ordinary_in;
            MODE_MEM:  w_live = memory_in;
            MODE_PC:   w_live = pc_in;
            MODE_STAT: w_live = w_stat_word;
            default:   w_live = ordinary_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_display <= '0;
        end else if (!r_sync[4]) begin
            r_display <= w_live;
        end
    end

    assign mode        = r_mode;
    assign stat_sel    = r_stat_sel;
    assign frozen      = r_sync[4];
    assign display_out = r_display;

endmodule
`default_nettype wire

// File: tb/tb_dashboard_view_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dashboard_view_ctrl
// Brief    : Directed table-driven bench for dashboard_view_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dashboard_view_ctrl;

    localparam int DATA_W = 32;
    localparam int NUM_STAT = 3;
    localparam int SEL_W = 2;
    localparam int NV = 22;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic                       freeze_sw = 1'b0, scroll_sw = 1'b0;
    logic [DATA_W-1:0]          ordinary_in = 32'd1;
    logic [DATA_W-1:0]          memory_in = 32'd2;
    logic [DATA_W-1:0]          pc_in = 32'd3;
    logic [NUM_STAT*DATA_W-1:0] stat_in = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    logic [1:0]                 mode;
    logic [SEL_W-1:0]           stat_sel;
    logic                       frozen;
    logic [DATA_W-1:0]          display_out;

    int n_cmp = 0;
    int n_err = 0;

    dashboard_view_ctrl #(
        .DATA_W      (DATA_W),
        .NUM_STAT    (NUM_STAT),
        .DEBOUNCE    (4),
        .SCROLL_TICKS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .freeze_sw  (freeze_sw),
        .scroll_sw  (scroll_sw),
        .ordinary_in(ordinary_in),
        .memory_in  (memory_in),
        .pc_in      (pc_in),
        .stat_in    (stat_in),
        .mode       (mode),
        .stat_sel   (stat_sel),
        .frozen     (frozen),
        .display_out(display_out)
    );

    always #5 clk = ~clk;

    // btn bit order: 0=U 1=D 2=L 3=R
    typedef struct {
        logic [3:0]  btn;
        int          cycles;
        logic [1:0]  exp_mode;
        logic [1:0]  exp_sel;
        logic [31:0] exp_disp;
    } vec_t;

    vec_t vecs [NV];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_btn(input logic [3:0] b);
        btn_u = b[0];
        btn_d = b[1];
        btn_l = b[2];
        btn_r = b[3];
    endtask

    task automatic chk_state(input string tag, input logic [1:0] m, input logic [1:0] s,
                             input logic [31:0] d);
        chk({tag, ".mode"}, {30'b0, mode}, {30'b0, m});
        chk({tag, ".sel"}, {30'b0, stat_sel}, {30'b0, s});
        chk({tag, ".disp"}, display_out, d);
    endtask

    // Counts negedges until stat_sel changes; returns limit+1 on timeout.
    task automatic wait_sel_change(input int limit, output int n);
        logic [SEL_W-1:0] old;
        old = stat_sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stat_sel == old && n <= limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{4'b0000, 8, 2'd1, 2'd0, 32'h2};
        vecs[1]  = '{4'b0001, 8, 2'd0, 2'd0, 32'h1};
        vecs[2]  = '{4'b0000, 8, 2'd0, 2'd0, 32'h1};
        vecs[3]  = '{4'b0100, 3, 2'd0, 2'd0, 32'h1};
        vecs[4]  = '{4'b0000, 8, 2'd0, 2'd0, 32'h1};
        vecs[5]  = '{4'b0100, 4, 2'd0, 2'd0, 32'h1};
        vecs[6]  = '{4'b0000, 8, 2'd2, 2'd0, 32'h3};
        vecs[7]  = '{4'b1000, 8, 2'd3, 2'd0, 32'hAAAA};
        vecs[8]  = '{4'b1000, 8, 2'd3, 2'd0, 32'hAAAA};
        vecs[9]  = '{4'b0000, 8, 2'd3, 2'd0, 32'hAAAA};
        vecs[10] = '{4'b1000, 8, 2'd3, 2'd1, 32'hBBBB};
        vecs[11] = '{4'b0000, 8, 2'd3, 2'd1, 32'hBBBB};
        vecs[12] = '{4'b1000, 8, 2'd3, 2'd2, 32'hCCCC};
        vecs[13] = '{4'b0000, 8, 2'd3, 2'd2, 32'hCCCC};
        vecs[14] = '{4'b1000, 8, 2'd3, 2'd0, 32'hAAAA};
        vecs[15] = '{4'b0000, 8, 2'd3, 2'd0, 32'hAAAA};
        vecs[16] = '{4'b1000, 8, 2'd3, 2'd1, 32'hBBBB};
        vecs[17] = '{4'b0000, 8, 2'd3, 2'd1, 32'hBBBB};
        vecs[18] = '{4'b0001, 8, 2'd0, 2'd1, 32'h1};
        vecs[19] = '{4'b0000, 8, 2'd0, 2'd1, 32'h1};
        vecs[20] = '{4'b1001, 8, 2'd0, 2'd1, 32'h1};
        vecs[21] = '{4'b0000, 8, 2'd0, 2'd1, 32'h1};

        // Reset and idle
        step(2);
        chk_state("in_reset", 2'd0, 2'd0, 32'h0);
        reset = 1'b0;
        step(2);
        chk_state("after_reset", 2'd0, 2'd0, 32'h1);
        chk("after_reset.frozen", {31'b0, frozen}, 32'h0);

        // D held from before edge 1: mode at edge 7, display at edge 8
        btn_d = 1'b1;
        step(6);
        chk("lat.mode_e6", {30'b0, mode}, 32'h0);
        step(1);
        chk("lat.mode_e7", {30'b0, mode}, 32'h1);
        chk("lat.disp_e7", display_out, 32'h1);
        step(1);
        chk("lat.disp_e8", display_out, 32'h2);

        for (int i = 0; i < NV; i++) begin
            drive_btn(vecs[i].btn);
            step(vecs[i].cycles);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_mode, vecs[i].exp_sel, vecs[i].exp_disp);
        end

        // R from ORD enters STAT keeping stat_sel
        drive_btn(4'b1000);
        step(8);
        chk_state("r_enter", 2'd3, 2'd1, 32'hBBBB);
        drive_btn(4'b0000);
        step(8);

        // Auto-scroll
        scroll_sw = 1'b1;
        wait_sel_change(20, n);
        chk("scroll.first_sel", {30'b0, stat_sel}, 32'h2);
        wait_sel_change(20, n);
        chk("scroll.period1", n, 8);
        chk("scroll.sel_wrap", {30'b0, stat_sel}, 32'h0);
        wait_sel_change(20, n);
        chk("scroll.period2", n, 8);
        chk("scroll.sel1", {30'b0, stat_sel}, 32'h1);

        // R press mid-period: one increment, period restarts
        btn_r = 1'b1;
        wait_sel_change(20, n);
        btn_r = 1'b0;
        chk("scroll.rpress_lat", n, 7);
        chk("scroll.rpress_sel", {30'b0, stat_sel}, 32'h2);
        wait_sel_change(20, n);
        chk("scroll.after_r", n, 8);
        chk("scroll.after_r_sel", {30'b0, stat_sel}, 32'h0);

        // Leaving STAT stops scrolling
        btn_d = 1'b1;
        step(8);
        chk_state("scroll.d_press", 2'd1, 2'd0, 32'h2);
        btn_d = 1'b0;
        step(16);
        chk_state("scroll.mem_idle", 2'd1, 2'd0, 32'h2);

        // Re-entering STAT: counter starts from 0
        btn_r = 1'b1;
        n = 0;
        while (mode != 2'd3 && n <= 20) begin
            @(negedge clk);
            n++;
        end
        chk("scroll.reenter_lat", n, 7);
        btn_r = 1'b0;
        wait_sel_change(20, n);
        chk("scroll.reenter_period", n, 8);
        chk("scroll.reenter_sel", {30'b0, stat_sel}, 32'h1);
        scroll_sw = 1'b0;
        step(8);

        // Freeze in PC mode
        btn_l = 1'b1;
        step(8);
        btn_l = 1'b0;
        step(8);
        chk_state("pc_mode", 2'd2, 2'd1, 32'h3);
        freeze_sw = 1'b1;
        step(1);
        chk("frz.frozen_e1", {31'b0, frozen}, 32'h0);
        step(1);
        chk("frz.frozen_e2", {31'b0, frozen}, 32'h1);
        pc_in = 32'd9;
        step(2);
        chk("frz.hold_pc", display_out, 32'h3);
        btn_u = 1'b1;
        step(8);
        btn_u = 1'b0;
        chk("frz.mode", {30'b0, mode}, 32'h0);
        chk("frz.hold_u", display_out, 32'h3);
        step(8);
        freeze_sw = 1'b0;
        step(2);
        chk("frz.rel_frozen", {31'b0, frozen}, 32'h0);
        chk("frz.rel_e2", display_out, 32'h3);
        step(1);
        chk("frz.rel_e3", display_out, 32'h1);

        // Asynchronous reset mid-debounce, with outputs non-zero
        btn_r = 1'b1;
        step(8);
        btn_r = 1'b0;
        step(8);
        chk_state("pre_rst", 2'd3, 2'd1, 32'hBBBB);
        freeze_sw = 1'b1;
        btn_d = 1'b1;
        step(3);
        chk("pre_rst.frozen", {31'b0, frozen}, 32'h1);
        reset = 1'b1;
        #1;
        chk_state("async_rst", 2'd0, 2'd0, 32'h0);
        chk("async_rst.frozen", {31'b0, frozen}, 32'h0);
        @(negedge clk);
        freeze_sw = 1'b0;
        btn_d = 1'b0;
        reset = 1'b0;
        step(3);
        chk_state("post_rst", 2'd0, 2'd0, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
